vga_fb_arbiter: RTL and testbench
=================================

VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

Interface
REQ-001 The block SHALL have parameter AW, default 17, framebuffer address width.
REQ-002 The block SHALL have parameter DW, default 8, pixel data width.
REQ-003 The block SHALL have parameter DEPTH, default 4, host write-buffer entries (power of 2, >=2).
REQ-004 The block SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-005 The block SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 The block SHALL have port disp_req  input  1  display read request, one access per asserted cycle.
REQ-007 The block SHALL have port disp_addr  input  AW  display read address, sampled with disp_req.
REQ-008 The block SHALL have port disp_data  output  DW  display read data.
REQ-009 The block SHALL have port disp_valid  output  1  disp_data valid, one-cycle pulse per request.
REQ-010 The block SHALL have port host_req  input  1  host access request, transfer occurs when host_req and host_ready are both 1.
REQ-011 The block SHALL have port host_we  input  1  1 = write, 0 = read.
REQ-012 The block SHALL have port host_addr  input  AW  host address.
REQ-013 The block SHALL have port host_wdata  input  DW  host write data.
REQ-014 The block SHALL have port host_ready  output  1  host request acceptance.
REQ-015 The block SHALL have port host_rdata  output  DW  host read data.
REQ-016 The block SHALL have port host_rvalid  output  1  host_rdata valid, one-cycle pulse.
REQ-017 The block SHALL have ports mem_en, mem_we (output, 1), mem_addr (output, AW), mem_wdata (output, DW) and mem_rdata (input, DW) to a single-port synchronous RAM with 1-cycle read latency.
REQ-018 The block SHALL have port fifo_level  output  $clog2(DEPTH)+1  current write-buffer occupancy.

Function
REQ-019 Memory port: at most one access per cycle; mem_* driven combinationally from the current cycle's grant; mem_en=0, mem_we=0 when idle.
REQ-020 Grant priority, per cycle: disp_req > pending host read (only when buffer empty) > buffer-head write.
REQ-021 Display read: disp_req in cycle N -> mem_addr=disp_addr, mem_we=0 in N; disp_valid=1 with disp_data=mem_rdata registered in N+2.
REQ-022 Back-to-back disp_req SHALL be fully pipelined; every request yields exactly one disp_valid, in order, no bubbles.
REQ-023 Host FSM states: H_IDLE, H_RD_PEND, H_RD_DATA.
REQ-024 host_ready = (state==H_IDLE) and (fifo_level<DEPTH); computed from current-cycle count, no full-buffer pass-through.
REQ-025 Accepted write pushes {addr,data} into the FIFO; state unchanged.
REQ-026 Accepted read latches host_addr; H_IDLE -> H_RD_PEND.
REQ-027 H_RD_PEND: read issued in first cycle with no disp_req and empty FIFO; transition -> H_RD_DATA.
REQ-028 H_RD_DATA: next cycle capture mem_rdata into host_rdata, pulse host_rvalid; -> H_IDLE. Read latency issue->rvalid = 2 cycles, matching the display path.
REQ-029 FIFO head SHALL pop and write memory in any cycle with no disp_req and no issuable host read.
REQ-030 Simultaneous push and pop: fifo_level unchanged; FIFO order preserved.
REQ-031 Buffered writes always precede a later host read to any address (read-after-write ordering via REQ-027).
REQ-032 Display reads are not ordered against buffered writes; a display read may return pre-write data.
REQ-033 No fairness: continuous disp_req stalls host indefinitely without data loss.
REQ-034 host_rdata holds its value until the next host read completes.

Reset
REQ-035 On rst: FIFO emptied (fifo_level=0), state H_IDLE, disp_valid=0, host_rvalid=0, disp_data=0, host_rdata=0, pipeline valid bits cleared.
REQ-036 Reset mid-operation: buffered writes discarded, in-flight reads produce no valid pulse; host_ready=1 in the first cycle after release.

Verification
REQ-037 Reset, then disp_req 1 cycle, addr=0x00010, RAM[0x10]=0xA5 -> mem_en=1, mem_we=0 same cycle; disp_valid=1, disp_data=0xA5 two cycles later.
REQ-038 4 host writes with disp_req held high -> host_ready=0 after 4th; fifo_level=4; no mem_we until disp_req drops, then 4 writes in order in 4 cycles.
REQ-039 Host write 0x3C to 0x00100, then immediate host read 0x00100 -> mem write precedes mem read; host_rvalid with host_rdata=0x3C.
REQ-040 disp_req every cycle for 640 cycles, host write pending -> 640 disp_valid pulses, contiguous; host write issued in first free cycle after.
REQ-041 rst asserted with fifo_level=3 and a host read in H_RD_PEND -> fifo_level=0, no host_rvalid, no mem_we after reset.
REQ-042 Host push while FIFO draining at fifo_level=2 -> fifo_level stays 2 that cycle.

Source files
------------

// File: rtl/vga_fb_arbiter.sv
// ---------------------------------------------------------------------------
// vga_fb_arbiter
// Shares one single-port synchronous framebuffer RAM (1-cycle read latency)
// between a display scan-out read port and a host read/write port.
//  - Display reads have absolute priority and are fully pipelined.
//  - Host writes are posted into a small FIFO and drained in idle cycles.
//  - A host read waits until the FIFO is empty, so it always observes every
//    earlier host write (read-after-write ordering).
//  - Display reads are not ordered against posted writes.
// ---------------------------------------------------------------------------
module vga_fb_arbiter #(
  parameter int AW    = 17,
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  // display read port
  input  logic                     disp_req,
  input  logic [AW-1:0]            disp_addr,
  output logic [DW-1:0]            disp_data,
  output logic                     disp_valid,
  // host port
  input  logic                     host_req,
  input  logic                     host_we,
  input  logic [AW-1:0]            host_addr,
  input  logic [DW-1:0]            host_wdata,
  output logic                     host_ready,
  output logic [DW-1:0]            host_rdata,
  output logic                     host_rvalid,
  // framebuffer RAM port
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [AW-1:0]            mem_addr,
  output logic [DW-1:0]            mem_wdata,
  input  logic [DW-1:0]            mem_rdata,
  // write-buffer occupancy
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  localparam logic [LW-1:0] LVL_ZERO = {LW{1'b0}};
  localparam logic [LW-1:0] LVL_ONE  = LW'(1);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
  localparam logic [PW-1:0] PTR_ZERO = {PW{1'b0}};
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  typedef enum logic [1:0] {
    H_IDLE    = 2'd0,
    H_RD_PEND = 2'd1,
    H_RD_DATA = 2'd2
  } host_state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  host_state_t   state_r;
  host_state_t   next_state_s;

  logic [AW-1:0] fifo_addr_r [DEPTH];
  logic [DW-1:0] fifo_data_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [LW-1:0] level_r;
  logic [LW-1:0] level_next_s;

  logic [AW-1:0] rd_addr_r;       // latched host read address

  logic          disp_pend_r;     // display read issued last cycle, RAM data now valid
  logic          disp_valid_r;
  logic [DW-1:0] disp_data_r;
  logic          host_rvalid_r;
  logic [DW-1:0] host_rdata_r;

  // ---------------------------------------------------------------------------
  // Combinational decode
  // ---------------------------------------------------------------------------
  logic fifo_empty_s;
  logic host_ready_s;
  logic push_s;
  logic pop_s;
  logic rd_accept_s;
  logic host_rd_gnt_s;

  // Handshake and grant decode: display first, then a pending host read
  // (only once the write buffer is empty), then the buffer head write.
  always_comb begin
    fifo_empty_s  = (level_r == LVL_ZERO);
    host_ready_s  = (state_r == H_IDLE) && (level_r < LVL_FULL);
    push_s        = host_req && host_ready_s && host_we;
    rd_accept_s   = host_req && host_ready_s && !host_we;
    if (disp_req) begin
      host_rd_gnt_s = 1'b0;
      pop_s         = 1'b0;
    end else if ((state_r == H_RD_PEND) && fifo_empty_s) begin
      host_rd_gnt_s = 1'b1;
      pop_s         = 1'b0;
    end else begin
      host_rd_gnt_s = 1'b0;
      pop_s         = !fifo_empty_s;
    end
  end

  // RAM port driven straight from this cycle's grant; fully idle otherwise.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = {AW{1'b0}};
    mem_wdata = {DW{1'b0}};
    if (disp_req) begin
      mem_en   = 1'b1;
      mem_addr = disp_addr;
    end else if (host_rd_gnt_s) begin
      mem_en   = 1'b1;
      mem_addr = rd_addr_r;
    end else if (pop_s) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = fifo_addr_r[rd_ptr_r];
      mem_wdata = fifo_data_r[rd_ptr_r];
    end else begin
      mem_en = 1'b0;
    end
  end

  // Host FSM next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      H_IDLE: begin
        if (rd_accept_s) begin
          next_state_s = H_RD_PEND;
        end else begin
          next_state_s = H_IDLE;
        end
      end
      H_RD_PEND: begin
        if (host_rd_gnt_s) begin
          next_state_s = H_RD_DATA;
        end else begin
          next_state_s = H_RD_PEND;
        end
      end
      H_RD_DATA: begin
        next_state_s = H_IDLE;
      end
      default: begin
        next_state_s = H_IDLE;
      end
    endcase
  end

  // Occupancy update; a simultaneous push and pop leaves the level unchanged.
  always_comb begin
    level_next_s = level_r;
    case ({push_s, pop_s})
      2'b10:   level_next_s = level_r + LVL_ONE;
      2'b01:   level_next_s = level_r - LVL_ONE;
      default: level_next_s = level_r;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sequential logic
  // ---------------------------------------------------------------------------

  // Host FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= H_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Write-buffer pointers and occupancy; reset discards all posted writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      level_r  <= LVL_ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      level_r <= level_next_s;
    end
  end

  // Write-buffer storage; contents are only meaningful below the level count.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_addr_r[wr_ptr_r] <= host_addr;
      fifo_data_r[wr_ptr_r] <= host_wdata;
    end
  end

  // Host read address latched on acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_addr_r <= {AW{1'b0}};
    end else if (rd_accept_s) begin
      rd_addr_r <= host_addr;
    end
  end

  // Display return pipeline: issue -> RAM latency -> registered output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_pend_r  <= 1'b0;
      disp_valid_r <= 1'b0;
      disp_data_r  <= {DW{1'b0}};
    end else begin
      disp_pend_r  <= disp_req;
      disp_valid_r <= disp_pend_r;
      if (disp_pend_r) begin
        disp_data_r <= mem_rdata;
      end
    end
  end

  // Host read return: capture RAM data one cycle after issue; held until the next read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      host_rvalid_r <= 1'b0;
      host_rdata_r  <= {DW{1'b0}};
    end else if (state_r == H_RD_DATA) begin
      host_rvalid_r <= 1'b1;
      host_rdata_r  <= mem_rdata;
    end else begin
      host_rvalid_r <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign disp_valid  = disp_valid_r;
  assign disp_data   = disp_data_r;
  assign host_rvalid = host_rvalid_r;
  assign host_rdata  = host_rdata_r;
  assign host_ready  = host_ready_s;
  assign fifo_level  = level_r;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// ---------------------------------------------------------------------------
// Self-checking bench for vga_fb_arbiter with a behavioural 1-cycle RAM.
// Expected read data is queued when a request is driven and compared when
// the corresponding valid pulse appears.
// ---------------------------------------------------------------------------
module tb_vga_fb_arbiter;

  localparam int AW    = 17;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          disp_req;
  logic [AW-1:0] disp_addr;
  logic [DW-1:0] disp_data;
  logic          disp_valid;
  logic          host_req;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_ready;
  logic [DW-1:0] host_rdata;
  logic          host_rvalid;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [LW-1:0] fifo_level;

  vga_fb_arbiter #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_data(disp_data), .disp_valid(disp_valid),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ready(host_ready), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  // behavioural single-port RAM, read-before-write, 1-cycle latency
  logic [DW-1:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [31:0]   c;
  } wr_t;

  logic [DW-1:0] disp_exp [$];
  logic [DW-1:0] host_exp [$];
  wr_t           wlog [$];
  logic [DW-1:0] shadow [int];
  int            disp_cnt = 0;
  int            disp_last = 0;
  int            rd_issue_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    if (a == 17'h00010) return 8'hA5;
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
    if (shadow.exists(int'(a))) return shadow[int'(a)];
    return init_val(a);
  endfunction

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // display reads only touch 0x00000-0x000FF, which the host never writes
  task automatic disp_set(input logic [AW-1:0] a);
    disp_req  = 1'b1;
    disp_addr = a;
    disp_exp.push_back(init_val(a));
  endtask

  task automatic host_xfer(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n;
    n = 0;
    host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d;
    @(negedge clk);
    while (!host_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!host_ready) chk("host_handshake_timeout", 32'd0, 32'd1);
    else if (we) shadow[int'(a)] = d;
    else host_exp.push_back(model_rd(a));
    @(posedge clk);
    #1;
    host_req = 1'b0; host_we = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    @(negedge clk);
    while ((disp_exp.size() != 0 || host_exp.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (disp_exp.size() != 0) chk("disp_drain_timeout", 32'(disp_exp.size()), 32'd0);
    if (host_exp.size() != 0) chk("host_drain_timeout", 32'(host_exp.size()), 32'd0);
  endtask

  // scoreboard / monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (disp_valid) begin
        disp_cnt++;
        disp_last = cyc;
        if (disp_exp.size() == 0) chk("disp_unexpected", 32'd1, 32'd0);
        else chk("disp_data", 32'(disp_data), 32'(disp_exp.pop_front()));
      end
      if (host_rvalid) begin
        if (host_exp.size() == 0) chk("host_unexpected", 32'd1, 32'd0);
        else chk("host_rdata", 32'(host_rdata), 32'(host_exp.pop_front()));
      end
      if (disp_req) chk("prio_no_we", 32'(mem_we), 32'd0);
      if (mem_en && mem_we) wlog.push_back(wr_t'({mem_addr, mem_wdata, 32'(cyc)}));
      if (mem_en && !mem_we && !disp_req) rd_issue_cyc = cyc;
    end
  end

  initial begin
    int wbase;
    int cstart;
    int cnt0;
    rst = 1'b1; disp_req = 1'b0; disp_addr = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    for (int i = 0; i < (1 << AW); i++) ram[i] = init_val(AW'(i));

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_disp_valid", 32'(disp_valid), 32'd0);
    chk("rst_disp_data", 32'(disp_data), 32'd0);
    chk("rst_host_rvalid", 32'(host_rvalid), 32'd0);
    chk("rst_host_rdata", 32'(host_rdata), 32'd0);
    chk("rst_fifo_level", 32'(fifo_level), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    next_cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_host_ready", 32'(host_ready), 32'd1);

    // single display read, latency 2
    next_cyc();
    disp_set(17'h00010);
    @(negedge clk);
    chk("d1_mem_en", 32'(mem_en), 32'd1);
    chk("d1_mem_we", 32'(mem_we), 32'd0);
    chk("d1_mem_addr", 32'(mem_addr), 32'h10);
    next_cyc();
    disp_req = 1'b0;
    @(negedge clk);
    chk("d1_valid_n1", 32'(disp_valid), 32'd0);
    @(negedge clk);
    chk("d1_valid_n2", 32'(disp_valid), 32'd1);
    chk("d1_data_n2", 32'(disp_data), 32'hA5);

    // four posted writes while the display holds the RAM
    next_cyc();
    for (int i = 0; i < 4; i++) begin
      disp_set(AW'(32'h20 + i));
      host_req = 1'b1; host_we = 1'b1;
      host_addr = AW'(32'h200 + i); host_wdata = DW'(32'h10 + i);
      @(negedge clk);
      chk("fill_ready", 32'(host_ready), 32'd1);
      shadow[32'h200 + i] = DW'(32'h10 + i);
      next_cyc();
    end
    host_req = 1'b0; host_we = 1'b0;
    disp_set(17'h00024);
    @(negedge clk);
    chk("full_ready", 32'(host_ready), 32'd0);
    chk("full_level", 32'(fifo_level), 32'd4);
    next_cyc();
    disp_req = 1'b0;
    wbase = wlog.size();
    repeat (4) next_cyc();
    @(negedge clk);
    chk("drain_level", 32'(fifo_level), 32'd0);
    chk("drain_count", 32'(wlog.size() - wbase), 32'd4);
    if (wlog.size() >= wbase + 4) begin
      for (int j = 0; j < 4; j++) begin
        chk("drain_addr", 32'(wlog[wbase + j].a), 32'h200 + j);
        chk("drain_data", 32'(wlog[wbase + j].d), 32'h10 + j);
      end
      chk("drain_span", wlog[wbase + 3].c - wlog[wbase].c, 32'd3);
    end

    // write then immediate read of same address
    next_cyc();
    wbase = wlog.size();
    host_xfer(1'b1, 17'h00100, 8'h3C);
    host_xfer(1'b0, 17'h00100, 8'h00);
    wait_drain();
    chk("raw_write_seen", 32'(wlog.size() - wbase), 32'd1);
    if (wlog.size() > wbase) chk("raw_order", 32'(wlog[wbase].c < 32'(rd_issue_cyc)), 32'd1);
    chk("raw_rdata", 32'(host_rdata), 32'h3C);
    repeat (5) next_cyc();
    @(negedge clk);
    chk("rdata_hold", 32'(host_rdata), 32'h3C);

    // 640-cycle display burst with a posted write waiting
    next_cyc();
    cstart = cyc;
    cnt0 = disp_cnt;
    for (int i = 0; i < 640; i++) begin
      disp_set(AW'(i & 255));
      if (i == 0) begin
        host_req = 1'b1; host_we = 1'b1; host_addr = 17'h00300; host_wdata = 8'h77;
      end else begin
        host_req = 1'b0; host_we = 1'b0;
      end
      @(negedge clk);
      if (i == 0) begin
        chk("burst_ready", 32'(host_ready), 32'd1);
        shadow[32'h300] = 8'h77;
      end
      next_cyc();
    end
    disp_req = 1'b0;
    @(negedge clk);
    chk("burst_free_we", 32'(mem_we), 32'd1);
    chk("burst_free_addr", 32'(mem_addr), 32'h300);
    chk("burst_free_wdata", 32'(mem_wdata), 32'h77);
    repeat (3) next_cyc();
    @(negedge clk);
    chk("burst_pulses", 32'(disp_cnt - cnt0), 32'd640);
    chk("burst_last", 32'(disp_last - cstart), 32'd641);
    next_cyc();
    host_xfer(1'b0, 17'h00300, 8'h00);
    wait_drain();

    // push while draining at level 2
    next_cyc();
    for (int i = 0; i < 3; i++) begin
      disp_set(AW'(32'h40 + i));
      host_req = 1'b1; host_we = 1'b1;
      host_addr = AW'(32'h400 + i); host_wdata = DW'(32'h50 + i);
      @(negedge clk);
      chk("pd_ready", 32'(host_ready), 32'd1);
      shadow[32'h400 + i] = DW'(32'h50 + i);
      next_cyc();
    end
    host_req = 1'b0; host_we = 1'b0; disp_req = 1'b0;
    @(negedge clk);
    chk("pd_level3", 32'(fifo_level), 32'd3);
    next_cyc();
    host_req = 1'b1; host_we = 1'b1; host_addr = 17'h00403; host_wdata = 8'h53;
    @(negedge clk);
    chk("pd_level2", 32'(fifo_level), 32'd2);
    chk("pd_pop_we", 32'(mem_we), 32'd1);
    chk("pd_push_ready", 32'(host_ready), 32'd1);
    shadow[32'h403] = 8'h53;
    next_cyc();
    host_req = 1'b0; host_we = 1'b0;
    @(negedge clk);
    chk("pd_level_hold", 32'(fifo_level), 32'd2);
    next_cyc();
    host_xfer(1'b0, 17'h00403, 8'h00);
    host_xfer(1'b0, 17'h00400, 8'h00);
    wait_drain();

    // reset with posted writes and a pending host read
    next_cyc();
    for (int i = 0; i < 3; i++) begin
      disp_set(AW'(32'h60 + i));
      host_req = 1'b1; host_we = 1'b1;
      host_addr = AW'(32'h500 + i); host_wdata = DW'(32'hE0 + i);
      @(negedge clk);
      chk("rm_ready", 32'(host_ready), 32'd1);
      next_cyc();
    end
    disp_set(17'h00063);
    host_req = 1'b1; host_we = 1'b0; host_addr = 17'h00200;
    @(negedge clk);
    chk("rm_rd_ready", 32'(host_ready), 32'd1);
    next_cyc();
    host_req = 1'b0;
    disp_set(17'h00064);
    @(negedge clk);
    chk("rm_level3", 32'(fifo_level), 32'd3);
    chk("rm_pend", 32'(host_ready), 32'd0);
    #2;
    rst = 1'b1;
    disp_req = 1'b0;
    disp_exp.delete();
    host_exp.delete();
    @(negedge clk);
    chk("rm_rst_level", 32'(fifo_level), 32'd0);
    chk("rm_rst_rvalid", 32'(host_rvalid), 32'd0);
    chk("rm_rst_dvalid", 32'(disp_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rm_release_ready", 32'(host_ready), 32'd1);
    chk("rm_release_level", 32'(fifo_level), 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("rm_no_we", 32'(mem_we), 32'd0);
      chk("rm_no_rvalid", 32'(host_rvalid), 32'd0);
    end

    wait_drain();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
